seven_seg_scan_mux: RTL
=======================

Name: seven_seg_scan_mux

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display.
- Selects one digit per refresh slot, decodes hex to active-low segments, and drives a one-hot active-low anode.
- Adds a ghost-suppression dead time, tear-free frame-synchronous loading, leading-zero blanking and decimal points.
- Sits between the arithmetic datapath (e.g. 4-bit adder result) and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; range 2..8.
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz).
- DEAD_CYCLES, 1000: cycles at slot start with all anodes off. Must satisfy 0 <= DEAD_CYCLES < REFRESH_DIV; elaboration error otherwise.
- BLANK_LEADING, 1: 1 = blank leading zero digits; 0 = always show.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 = display dark.
- load  in  1  single-cycle strobe; captures digits_i/dp_i/blank_i.
- digits_i  in  4*NUM_DIGITS  hex nibbles; digit k = bits [4k+3:4k], digit 0 rightmost.
- dp_i  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_i  in  NUM_DIGITS  forced blank per digit, 1 = dark.
- an_o  out  NUM_DIGITS  anode drive, active-low, at most one bit 0.
- seg_o  out  7  segments, active-low; bit0 = a ... bit6 = g.
- dp_o  out  1  decimal point, active-low.
- digit_idx_o  out  clog2(NUM_DIGITS)  digit currently in its slot.
- frame_o  out  1  one-cycle pulse when the index wraps from NUM_DIGITS-1 to 0.

Behaviour:
- Reset (async, rst_n=0):
  - an_o all 1, seg_o 7'h7F, dp_o 1, digit_idx_o 0, frame_o 0.
  - Prescaler 0, state OFF.
  - Shadow and display registers cleared (digits 0, dp 0, blank 0); pending flag 0.
- State machine:
  - OFF (en=0): anodes all 1; prescaler and idx held at 0.
  - OFF -> DEAD when en=1.
  - DEAD: anodes all 1. Go to ON when prescaler == DEAD_CYCLES-1; if DEAD_CYCLES=0, DEAD is skipped and scanning starts in ON.
  - ON: anode for idx driven low. When prescaler == REFRESH_DIV-1: prescaler := 0, idx := idx+1 (wraps NUM_DIGITS-1 -> 0), state := DEAD.
  - Any state -> OFF on the cycle after en=0. Prescaler and idx reset; pending load is kept.
- Prescaler: counts 0..REFRESH_DIV-1 in DEAD/ON. Slot length is exactly REFRESH_DIV cycles; full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Outputs: all registered; pins reflect the current state/idx with 1-cycle latency.
- frame_o: asserted for exactly the one cycle in which idx registers 0 after a wrap.
- Loading:
  - load=1 copies inputs into the shadow registers and sets pending.
  - The display registers take the shadow on the wrap cycle, so a frame never mixes old and new values.
  - Multiple loads before a wrap: the last one wins.
  - load coincident with the wrap: the new values apply at that wrap.
  - load while in OFF: the display registers update immediately; pending stays 0.
- Decode: display nibble -> active-low segments.
  - 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, F = 7'h0E; full 0-F table in the package.
- Blanking (digit shows seg 7'h7F, dp 1) when either holds:
  - blank_i bit set;
  - BLANK_LEADING=1, digit k > 0, and all digits k..NUM_DIGITS-1 are zero.
- Digit 0 is never leading-blanked.
- A blanked digit still drives its anode low, for uniform duty cycle.
- dp_o is low only when the digit is in ON, dp_i set and the digit not blanked.

Decomposition:
- Package seven_seg_pkg:
  - 16-entry active-low segment table (hex 0-F);
  - SEG_BLANK = 7'h7F;
  - state encoding OFF/DEAD/ON.
- Sub-module hex_to_seg: combinational nibble -> 7-bit active-low segments. Instantiated once, on the selected digit.

Test Plan:
- Reset/enable (REFRESH_DIV=4, DEAD_CYCLES=1): hold rst_n=0 -> an_o=4'hF, seg_o=7'h7F, dp_o=1. Release with en=1 -> anode low sequence 4'hE, 4'hD, 4'hB, 4'h7 with 3 cycles on and 1 dead per slot; frame_o pulses every 16 cycles.
- Decode and decimal point: load digits 16'h8F10, dp_i=4'b0100, BLANK_LEADING=0 -> segments per slot:
  - digit0 = 7'h40;
  - digit1 = 7'h79;
  - digit2 = 7'h0E with dp_o=0;
  - digit3 = 7'h00.
- Leading zero blanking: load 16'h0050 with BLANK_LEADING=1 -> digits 3 and 2 show 7'h7F, digit 1 shows 5, digit 0 shows 0 (7'h40). Load 16'h0000 -> only digit 0 lit.
- Tear-free load: strobe load=16'h1234 while the digit 2 slot is active -> digits 2 and 3 in the current frame still show old values; 1234 appears from the next frame_o onward. Two loads in one frame -> only the second is displayed.
- Enable drop mid-slot: deassert en while digit 1 is ON -> next cycle an_o=4'hF and idx=0. A load while disabled applies immediately. Re-enable -> scan restarts at digit 0 with a DEAD slot.
- Async reset mid-scan: pulse rst_n low between clock edges -> outputs go to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// seven_seg_pkg: scan state encoding and the active-low hex segment table (bit0 = a ... bit6 = g). Rev 1.0
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the pattern for hex digit n (listed F down to 0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// hex_to_seg: combinational hex nibble to active-low 7-segment pattern. Rev 1.0
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_mux.sv
`default_nettype none
// seven_seg_scan_mux: time-multiplexed N-digit common-anode driver with dead time,
// frame-synchronous loading, leading-zero blanking and decimal points. Rev 1.0
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int DEAD_CYCLES   = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic [NUM_DIGITS-1:0]         blank_i,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [6:0]                    seg_o,
  output logic                          dp_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] DEAD_LAST = PRE_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam scan_state_t SLOT_START = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seven_seg_scan_mux: NUM_DIGITS must be in 2..8");
  end
  if (DEAD_CYCLES < 0 || DEAD_CYCLES >= REFRESH_DIV) begin : g_bad_dead
    $error("seven_seg_scan_mux: DEAD_CYCLES must satisfy 0 <= DEAD_CYCLES < REFRESH_DIV");
  end

  scan_state_t             state, state_nxt;
  logic [PRE_W-1:0]        presc, presc_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] sh_digits, sh_digits_nxt, disp_digits, disp_digits_nxt;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_nxt, disp_dp, disp_dp_nxt;
  logic [NUM_DIGITS-1:0]   sh_blank, sh_blank_nxt, disp_blank, disp_blank_nxt;
  logic                    pending, pending_nxt;

  logic [NUM_DIGITS-1:0]   lead_blank;
  logic                    zero_run;
  logic [3:0]              sel_nibble;
  logic [6:0]              dec_seg;
  logic                    dark;
  logic                    lit;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    idx_nxt   = idx;
    wrap      = 1'b0;
    if (!en) begin
      state_nxt = ST_OFF;
      presc_nxt = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = SLOT_START;
          presc_nxt = '0;
        end
        ST_DEAD: begin
          presc_nxt = presc + PRE_W'(1);
          if (presc == DEAD_LAST) state_nxt = ST_ON;
        end
        ST_ON: begin
          if (presc == PRE_LAST) begin
            presc_nxt = '0;
            state_nxt = SLOT_START;
            wrap      = (idx == IDX_LAST);
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          end else begin
            presc_nxt = presc + PRE_W'(1);
          end
        end
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  // Shadow captures every load; the display copy only moves at a frame wrap,
  // except while dark, where there is no frame to tear.
  always_comb begin
    sh_digits_nxt   = sh_digits;
    sh_dp_nxt       = sh_dp;
    sh_blank_nxt    = sh_blank;
    pending_nxt     = pending;
    disp_digits_nxt = disp_digits;
    disp_dp_nxt     = disp_dp;
    disp_blank_nxt  = disp_blank;
    if (load) begin
      sh_digits_nxt = digits_i;
      sh_dp_nxt     = dp_i;
      sh_blank_nxt  = blank_i;
      pending_nxt   = 1'b1;
    end
    if (load && state == ST_OFF) begin
      disp_digits_nxt = digits_i;
      disp_dp_nxt     = dp_i;
      disp_blank_nxt  = blank_i;
      pending_nxt     = 1'b0;
    end else if (wrap && pending_nxt) begin
      disp_digits_nxt = sh_digits_nxt;
      disp_dp_nxt     = sh_dp_nxt;
      disp_blank_nxt  = sh_blank_nxt;
      pending_nxt     = 1'b0;
    end
  end

  always_comb begin
    lead_blank = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run      = zero_run && (disp_digits_nxt[4*k +: 4] == 4'h0);
      lead_blank[k] = zero_run && (BLANK_LEADING != 0);
    end
  end

  assign sel_nibble = disp_digits_nxt[{idx_nxt, 2'b00} +: 4];
  assign dark       = disp_blank_nxt[idx_nxt] | lead_blank[idx_nxt];
  assign lit        = (state_nxt == ST_ON) && !dark;

  hex_to_seg u_hex_to_seg (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

  // Pins are computed from next-state values so they line up with state/idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      presc       <= '0;
      idx         <= '0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      pending     <= 1'b0;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_blank  <= '0;
      an_o        <= '1;
      seg_o       <= SEG_BLANK;
      dp_o        <= 1'b1;
      frame_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      idx         <= idx_nxt;
      sh_digits   <= sh_digits_nxt;
      sh_dp       <= sh_dp_nxt;
      sh_blank    <= sh_blank_nxt;
      pending     <= pending_nxt;
      disp_digits <= disp_digits_nxt;
      disp_dp     <= disp_dp_nxt;
      disp_blank  <= disp_blank_nxt;
      an_o        <= (state_nxt == ST_ON) ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
      seg_o       <= lit ? dec_seg : SEG_BLANK;
      dp_o        <= !(lit && disp_dp_nxt[idx_nxt]);
      frame_o     <= wrap;
    end
  end

  assign digit_idx_o = idx;

endmodule
`default_nettype wire
